// File: rtl/unit_a_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one combinational unit_A adder among NREQ requesters.
// Optional macro UNIT_A_ARB_FLAGS_EN adds captured negative/zero result flags.
module unit_a_arbiter #(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned IDW          = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_f,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [1:0]           alu_f,
  input  logic [31:0]          alu_s,
  input  logic                 alu_c,
  input  logic                 alu_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_s,
  output logic                 rsp_c,
  output logic                 rsp_o,
  output logic                 rsp_n,
  output logic                 rsp_z,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         r_state;
  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_alu_a;
  logic [31:0]    r_alu_b;
  logic [1:0]     r_alu_f;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [31:0]    r_rsp_s;
  logic           r_rsp_c;
  logic           r_rsp_o;
  logic           r_busy;

  logic           w_found;
  logic [IDW-1:0] w_idx;

  // Search starts just after the last grant and wraps, giving round-robin fairness.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_idx   = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == StIdle && w_found) begin
      req_ready[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= IDW'(NREQ - 1);
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_f     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_s     <= '0;
      r_rsp_c     <= 1'b0;
      r_rsp_o     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_alu_a  <= req_a[32*w_idx +: 32];
            r_alu_b  <= req_b[32*w_idx +: 32];
            r_alu_f  <= req_f[2*w_idx +: 2];
            r_rsp_id <= w_idx;
            r_ptr    <= w_idx;
            r_cnt    <= CW'(SETTLE_CYCLES - 1);
            r_busy   <= 1'b1;
            r_state  <= StWait;
          end
        end
        StWait: begin
          if (r_cnt == '0) begin
            r_rsp_s     <= alu_s;
            r_rsp_c     <= alu_c;
            r_rsp_o     <= alu_o;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef UNIT_A_ARB_FLAGS_EN
  logic r_rsp_n;
  logic r_rsp_z;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_n <= 1'b0;
      r_rsp_z <= 1'b0;
    end else if (r_state == StWait && r_cnt == '0) begin
      r_rsp_n <= alu_s[31];
      r_rsp_z <= (alu_s == 32'd0);
    end
  end

  assign rsp_n = r_rsp_n;
  assign rsp_z = r_rsp_z;
`else
  assign rsp_n = 1'b0;
  assign rsp_z = 1'b0;
`endif

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_f     = r_alu_f;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_s     = r_rsp_s;
  assign rsp_c     = r_rsp_c;
  assign rsp_o     = r_rsp_o;
  assign busy      = r_busy;

endmodule

// File: tb/tb_unit_a_arbiter.sv
// Directed self-checking bench for unit_a_arbiter with a behavioural unit_A adder/subtractor.
module tb_unit_a_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned SETTLE = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_f;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [1:0]        alu_f;
  logic [31:0]       alu_s;
  logic              alu_c;
  logic              alu_o;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [31:0]       rsp_s;
  logic              rsp_c;
  logic              rsp_o;
  logic              rsp_n;
  logic              rsp_z;
  logic              busy;

  int n_total;
  int n_bad;

  unit_a_arbiter #(
    .NREQ         (NREQ),
    .SETTLE_CYCLES(SETTLE)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_f    (req_f),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .alu_s    (alu_s),
    .alu_c    (alu_c),
    .alu_o    (alu_o),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_s    (rsp_s),
    .rsp_c    (rsp_c),
    .rsp_o    (rsp_o),
    .rsp_n    (rsp_n),
    .rsp_z    (rsp_z),
    .busy     (busy)
  );

  // unit_A: s = x + y + cin with carry-out and signed overflow.
  logic [31:0] m_x;
  logic [31:0] m_y;
  logic        m_cin;
  logic [32:0] m_sum;

  always_comb begin
    m_x   = alu_a;
    m_y   = alu_b;
    m_cin = 1'b0;
    case (alu_f)
      2'b00: begin m_x = alu_a; m_y = alu_b;  m_cin = 1'b0; end
      2'b01: begin m_x = alu_a; m_y = ~alu_b; m_cin = 1'b1; end
      2'b10: begin m_x = 32'd0; m_y = ~alu_b; m_cin = 1'b1; end
      default: begin m_x = alu_b; m_y = 32'd0; m_cin = 1'b1; end
    endcase
    m_sum = {1'b0, m_x} + {1'b0, m_y} + {32'd0, m_cin};
  end

  assign alu_s = m_sum[31:0];
  assign alu_c = m_sum[32];
  assign alu_o = (m_x[31] == m_y[31]) && (m_sum[31] != m_x[31]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Called on the negedge after the grant edge; returns negedges from the grant cycle to rsp_valid.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(SETTLE + 1));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] f, input logic [31:0] es, input logic ec,
                       input logic eo);
    int n;
    logic en;
    logic ez;
`ifdef UNIT_A_ARB_FLAGS_EN
    en = es[31];
    ez = (es == 32'd0);
`else
    en = 1'b0;
    ez = 1'b0;
`endif
    req_a = '0;
    req_b = '0;
    req_f = '0;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_f[2*r +: 2]   = f;
    req_valid         = '0;
    req_valid[r]      = 1'b1;
    #1;
    chk("op_gnt", 32'(req_ready), 32'(req_valid));
    @(negedge clk);
    req_valid = '0;
    chk("op_alu_a", alu_a, a);
    chk("op_alu_f", 32'(alu_f), 32'(f));
    wait_rsp(n);
    chk("op_id", 32'(rsp_id), 32'(r));
    chk("op_s", rsp_s, es);
    chk("op_c", 32'(rsp_c), 32'(ec));
    chk("op_o", 32'(rsp_o), 32'(eo));
    chk("op_n", 32'(rsp_n), 32'(en));
    chk("op_z", 32'(rsp_z), 32'(ez));
    handshake();
    chk("op_done", {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_f     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_s", rsp_s, 32'd0);
    rst_n = 1'b1;

    // Contention: both requesters valid, req0 wins first.
    req_a = {32'd100, 32'd10};
    req_b = {32'd1, 32'd20};
    req_f = {2'b01, 2'b00};
    req_valid = 2'b11;
    #1;
    chk("cont_gnt0", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("cont_pulse0", 32'(req_ready), 32'd0);
    chk("cont_busy", 32'(busy), 32'd1);
    wait_rsp(n);
    chk("cont_id0", 32'(rsp_id), 32'd0);
    chk("cont_s0", rsp_s, 32'd30);
    handshake();
    chk("cont_gnt1", 32'(req_ready), 32'd2);
    @(negedge clk);
    chk("cont_pulse1", 32'(req_ready), 32'd0);
    wait_rsp(n);
    chk("cont_id1", 32'(rsp_id), 32'd1);
    chk("cont_s1", rsp_s, 32'd99);
    chk("cont_c1", 32'(rsp_c), 32'd1);

    // Backpressure with requests still pending.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_s", rsp_s, 32'd99);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    handshake();
    chk("bp_regrant", 32'(req_ready), 32'd1);
    chk("bp_valid_lo", 32'(rsp_valid), 32'd0);

    // Reset while in WAIT drops the operation.
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_alu_a", alu_a, 32'd0);
    chk("mid_alu_f", 32'(alu_f), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_id", 32'(rsp_id), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("mid_gnt0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("mid_id0", 32'(rsp_id), 32'd0);
    chk("mid_s0", rsp_s, 32'd30);
    handshake();

    // Valid withdrawn before the edge is not latched.
    req_valid = 2'b01;
    #1;
    chk("drop_gnt", 32'(req_ready), 32'd1);
    #2;
    req_valid = '0;
    @(negedge clk);
    chk("drop_busy", 32'(busy), 32'd0);

    do_op(0, 32'd5, 32'd7, 2'b00, 32'd12, 1'b0, 1'b0);
    do_op(1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(0, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 1'b0, 1'b1);
    do_op(1, 32'd0, 32'd1, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(0, 32'd0, 32'hFFFF_FFFF, 2'b11, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
